// File: rtl/pu_pkg.sv
// pu_pkg: shared widths, types and activation constants for the neuron processing unit
package pu_pkg;
    localparam int DATA_W = 5;
    localparam int FRAC_W = 3;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = 2 * DATA_W + 2;
    localparam logic [DATA_W-1:0] OUT_MAX = 5'b01111;
    localparam logic [DATA_W-1:0] OUT_MIN = '0;
    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;
    // Floor the full-precision sum to Q.3, then clamp into [0, OUT_MAX]
    function automatic logic [DATA_W-1:0] activate(input sum_t sum);
        sum_t s3;
        s3 = sum >>> FRAC_W;
        return s3[SUM_W-1] ? OUT_MIN :
               (s3 > sum_t'(OUT_MAX)) ? OUT_MAX : s3[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/processing_unit_if.sv
// processing_unit_if: operand, enable and result bundle between controller and processing unit
interface processing_unit_if;
    import pu_pkg::*;
    data_t x0, x1, x2, x3;
    data_t w0, w1, w2, w3;
    logic mult_reg_en;
    logic add_reg_en;
    logic Zero_signal;
    logic [DATA_W-1:0] new_value;
    modport master (
        output x0, x1, x2, x3, w0, w1, w2, w3, mult_reg_en, add_reg_en,
        input  Zero_signal, new_value
    );
    modport slave (
        input  x0, x1, x2, x3, w0, w1, w2, w3, mult_reg_en, add_reg_en,
        output Zero_signal, new_value
    );
endinterface

// File: rtl/pu_mult_stage.sv
// pu_mult_stage: full-precision signed multiply with an enabled product register
module pu_mult_stage
    import pu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en_i,
    input  data_t x_i,
    input  data_t w_i,
    output prod_t p_o
);
    prod_t p_q;
    prod_t p_d;
    assign p_d = prod_t'(x_i) * prod_t'(w_i);
    // Capture the product only on an enabled edge; async clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            p_q <= '0;
        else if (en_i)
            p_q <= p_d;
    end
    assign p_o = p_q;
endmodule

// File: rtl/processing_unit.sv
// processing_unit: four-input neuron with registered products, registered sum and saturating ReLU
module processing_unit
    import pu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    processing_unit_if.slave bus
);
    data_t x [4];
    data_t w [4];
    prod_t p [4];
    sum_t  sum_d;
    sum_t  sum_q;
    assign x[0] = bus.x0;
    assign x[1] = bus.x1;
    assign x[2] = bus.x2;
    assign x[3] = bus.x3;
    assign w[0] = bus.w0;
    assign w[1] = bus.w1;
    assign w[2] = bus.w2;
    assign w[3] = bus.w3;
    for (genvar i = 0; i < 4; i++) begin : g_mult
        pu_mult_stage u_mult (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (bus.mult_reg_en),
            .x_i   (x[i]),
            .w_i   (w[i]),
            .p_o   (p[i])
        );
    end
    // Adder tree over the registered products; two guard bits make overflow impossible
    always_comb begin
        sum_d = sum_t'(p[0]) + sum_t'(p[1]) + sum_t'(p[2]) + sum_t'(p[3]);
    end
    // Sum register loads only when the controller enables it; async clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum_q <= '0;
        else if (bus.add_reg_en)
            sum_q <= sum_d;
    end
    // Activation and zero flag follow the sum register combinationally
    always_comb begin
        bus.new_value   = activate(sum_q);
        bus.Zero_signal = (bus.new_value == OUT_MIN);
    end
endmodule

// File: tb/tb_processing_unit.sv
// tb_processing_unit: directed self-checking bench for processing_unit
module tb_processing_unit;
    import pu_pkg::*;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    processing_unit_if bus ();
    processing_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [4:0] nv, input logic z);
        checks++;
        assert (bus.new_value === nv && bus.Zero_signal === z)
        else begin
            errors++;
            $error("FAIL %s: new_value=%b Zero_signal=%b, expected new_value=%b Zero_signal=%b",
                   tag, bus.new_value, bus.Zero_signal, nv, z);
        end
    endtask
    task automatic set_x(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
        bus.x0 = a; bus.x1 = b; bus.x2 = c; bus.x3 = d;
    endtask
    task automatic set_w(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
        bus.w0 = a; bus.w1 = b; bus.w2 = c; bus.w3 = d;
    endtask
    // one clock with the given enables, driven and released on falling edges
    task automatic step(input logic m, input logic a);
        @(negedge clk);
        bus.mult_reg_en = m;
        bus.add_reg_en  = a;
        @(negedge clk);
        bus.mult_reg_en = 1'b0;
        bus.add_reg_en  = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0;
        bus.mult_reg_en = 1'b0;
        bus.add_reg_en  = 1'b0;
        set_x(5'b00000, 5'b00000, 5'b00000, 5'b00000);
        set_w(5'b00000, 5'b00000, 5'b00000, 5'b00000);
        #12;
        chk("reset_state", 5'b00000, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        // mixed signs: 4 - 8 + 8 + 12 = 16/64 -> 0.25
        set_x(5'b00010, 5'b11100, 5'b00100, 5'b00110);
        set_w(5'b00010, 5'b00010, 5'b00010, 5'b00010);
        step(1'b1, 1'b0);
        chk("mult_only_no_output", 5'b00000, 1'b1);
        step(1'b0, 1'b1);
        chk("mixed_signs", 5'b00010, 1'b0);
        // x1 = 0: 4 + 8 + 12 = 24/64 -> 0.375
        set_x(5'b00010, 5'b00000, 5'b00100, 5'b00110);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("x1_zero", 5'b00011, 1'b0);
        // negative: 4 * (-8 * 4) = -128/64 -> clamp to 0
        set_x(5'b11000, 5'b11000, 5'b11000, 5'b11000);
        set_w(5'b00100, 5'b00100, 5'b00100, 5'b00100);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("negative_sum", 5'b00000, 1'b1);
        // below 1/8: 1/64 floors to 0
        set_x(5'b00001, 5'b00000, 5'b00000, 5'b00000);
        set_w(5'b00001, 5'b00000, 5'b00000, 5'b00000);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("below_lsb", 5'b00000, 1'b1);
        // just under saturation: 14 * 8 = 112/64 -> 14/8
        set_x(5'b01110, 5'b00000, 5'b00000, 5'b00000);
        set_w(5'b01000, 5'b00000, 5'b00000, 5'b00000);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("near_max", 5'b01110, 1'b0);
        // negative sum restores 0 before gating tests
        set_x(5'b11000, 5'b11000, 5'b11000, 5'b11000);
        set_w(5'b00100, 5'b00100, 5'b00100, 5'b00100);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("negative_again", 5'b00000, 1'b1);
        // load saturating products without updating the sum
        set_x(5'b01111, 5'b01111, 5'b01111, 5'b01111);
        set_w(5'b01111, 5'b01111, 5'b01111, 5'b01111);
        step(1'b1, 1'b0);
        chk("sat_products_held", 5'b00000, 1'b1);
        // inputs change with enables low: nothing moves
        set_x(5'b00010, 5'b11100, 5'b00100, 5'b00110);
        set_w(5'b00010, 5'b00010, 5'b00010, 5'b00010);
        repeat (3) @(negedge clk);
        chk("idle_hold", 5'b00000, 1'b1);
        // add only: uses old saturating products (900/64 ~ 14.06)
        step(1'b0, 1'b1);
        chk("saturation_add_only", 5'b01111, 1'b0);
        // both enables two edges: edge1 sums old products, edge2 sums edge1 products
        @(negedge clk);
        bus.mult_reg_en = 1'b1;
        bus.add_reg_en  = 1'b1;
        @(negedge clk);
        chk("pipe_edge1", 5'b01111, 1'b0);
        set_x(5'b00010, 5'b00000, 5'b00100, 5'b00110);
        @(negedge clk);
        bus.mult_reg_en = 1'b0;
        bus.add_reg_en  = 1'b0;
        chk("pipe_edge2", 5'b00010, 1'b0);
        step(1'b0, 1'b1);
        chk("pipe_drain", 5'b00011, 1'b0);
        // async reset mid-cycle with nonzero state
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_immediate", 5'b00000, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("after_reset_hold", 5'b00000, 1'b1);
        // products were cleared too: add only yields zero
        step(1'b0, 1'b1);
        chk("products_cleared", 5'b00000, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("resume_after_reset", 5'b00011, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/processing_unit.md
# processing_unit

Four-input neuron processing unit: multiplies four signed fixed-point inputs by four weights, accumulates the products at full precision, and applies a saturating ReLU-style activation to produce one fixed-point output plus a zero flag. It sits in the network datapath under an external controller, which sequences the two register enables and uses `Zero_signal` for termination or selection decisions.

## Interface
- `DATA_W`, 5: width of inputs, weights and output (two's complement).
- `FRAC_W`, 3: fractional bits. Value = signed integer / 8, range −2.0 … +1.875.
- `clk`  in  1  system clock, rising edge. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `x0..x3`  in  5 each  signed Q2.3 inputs.
- `w0..w3`  in  5 each  signed Q2.3 weights.
- `mult_reg_en`  in  1  load the four product registers.
- `add_reg_en`  in  1  load the sum register.
- `Zero_signal`  out  1  high when `new_value` == 0.
- `new_value`  out  5  activated Q2.3 result.

## Operation
- Products: `p_i = x_i * w_i`, signed, kept at full precision (10 bits, 6 fractional bits). No truncation before the sum.
- Product registers: on a rising edge with `mult_reg_en`=1, all four `p_i` load. Otherwise they hold.
- Sum: the four registered products are sign-extended to 12 bits and added, with no overflow possible. On a rising edge with `add_reg_en`=1, the sum register loads. Otherwise it holds.
- Activation, combinational from the sum register:
  - `s3 = sum >>> 3` (arithmetic shift, i.e. floor to Q.3).
  - If `s3` < 0, `new_value` = 0.
  - If `s3` > 15, `new_value` = 5'b01111 (saturate).
  - Otherwise `new_value` = `s3[4:0]`.
- `Zero_signal` = (`new_value` == 0). It is high for negative sums, zero sums, and sums below 1/8.
- Both enables high on the same edge: the products load new values, and the sum loads from the old product registers. This is a normal two-stage pipeline.
- Inputs may change at any time. Only values present at an enabled edge matter.

## Timing
- Latency from inputs to `new_value` is two enabled edges:
  - Edge 1 with `mult_reg_en`.
  - Edge 2 with `add_reg_en`.
  - The output is valid combinationally after edge 2.
- Outputs hold indefinitely while both enables are low.
- Reset, asserted asynchronously at any time including mid-sequence:
  - Clears all product registers and the sum register.
  - `new_value` = 0 and `Zero_signal` = 1 immediately.
- After reset deasserts, operation resumes at the next enabled edge.
- No handshake: the controller guarantees sequencing.

## Structure
- Shared package `pu_pkg` holds:
  - `DATA_W`, `FRAC_W`.
  - Product width (`2*DATA_W`) and sum width (`2*DATA_W+2`).
  - Output saturation constants `OUT_MAX`=5'b01111 and `OUT_MIN`=0.
- One sub-module, `pu_mult_stage`: a signed multiplier plus its enabled product register with async reset, instantiated four times.
- Adder tree, sum register and activation live in the top level.

## Test plan
- Reset: assert `rst_n`=0 mid-sequence -> `new_value`=00000 and `Zero_signal`=1 at once; registers cleared.
- Mixed signs:
  - Stimulus: x={00010, 11100, 00100, 00110} (0.25, −0.5, 0.5, 0.75), all w=00010 (0.25). Pulse `mult_reg_en` for one cycle, then `add_reg_en` for one cycle.
  - Required: `new_value`=00010 (0.25), `Zero_signal`=0. This proves products are not truncated individually.
- Same vector with x1=00000 -> `new_value`=00011 (0.375).
- Negative sum: x all 11000 (−1.0), w all 00100 (0.5) -> sum −2.0 -> `new_value`=00000, `Zero_signal`=1.
- Saturation: x all 01111, w all 01111 -> sum ≈ 14.06 -> `new_value`=01111, `Zero_signal`=0.
- Enable gating:
  - Change x with both enables low -> output unchanged.
  - Pulse `add_reg_en` only -> output recomputes from the old products.
  - Assert both enables for two consecutive edges -> second-edge output reflects the first-edge products.
